// File: rtl/labmininios_lcd_pkg.sv
// Shared constants and types for the HD44780 LCD controller.
package labmininios_lcd_pkg;

  localparam int unsigned DATA_W = 9;
  localparam int unsigned RAW_W  = 11;

  // Sequencer states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_RAW     = 2'd3;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_LVL_LSB = 8;

  localparam int unsigned CTRL_RUN    = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_FLUSH  = 2;
  localparam int unsigned CTRL_RAW    = 3;

  // Clear / return-home style commands need the long execution wait
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  typedef struct packed {
    logic       rs;
    logic [7:0] dat;
  } lcd_entry_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_long_cmd(input lcd_entry_t e);
    return ~e.rs & ((e.dat == CMD_CLEAR) | (e.dat == CMD_HOME) | (e.dat == CMD_HOME_ALT));
  endfunction

endpackage

// File: rtl/labmininios_lcd_fifo.sv
// Synchronous command FIFO; flush beats push/pop, push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module labmininios_lcd_fifo
  import labmininios_lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  lcd_entry_t               wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output lcd_entry_t               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  lcd_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~flush_i & ~empty_o;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/labmininios_lcd_ctrl.sv
// Avalon-MM HD44780 LCD controller: register file, command FIFO, timing
// sequencer and registered pin drive with a legacy raw-pin mode.
module labmininios_lcd_ctrl
  import labmininios_lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SETUP_CYC  = 4,
  parameter int unsigned EN_CYC     = 13,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned EXEC_CYC   = 2000,
  parameter int unsigned LONG_CYC   = 82000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        irq
);

  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYC, EN_CYC),
                                                max_u(HOLD_CYC, EXEC_CYC)), LONG_CYC);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);

  logic             wr_c, push_c, flush_c, pop_c, ctrl_wr_c;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  lcd_entry_t       fifo_head;

  logic             run_q, irq_en_q, raw_mode_q, ovf_q;
  logic [RAW_W-1:0] raw_q;
  lcd_entry_t       ent_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lcd_data_q;
  logic             lcd_rs_q, lcd_rw_q, lcd_en_q;
  logic             unused_ok;

  assign wr_c      = chipselect & ~write_n;
  assign push_c    = wr_c & (address == REG_DATA);
  assign ctrl_wr_c = wr_c & (address == REG_CONTROL);
  assign flush_c   = ctrl_wr_c & writedata[CTRL_FLUSH];
  assign pop_c     = (state_q == S_IDLE) & run_q & ~raw_mode_q & ~fifo_empty & ~flush_c;
  assign unused_ok = ^{read_n, writedata[31:RAW_W]};

  labmininios_lcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_c),
    .wdata_i (lcd_entry_t'(writedata[DATA_W-1:0])),
    .pop_i   (pop_c),
    .flush_i (flush_c),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      raw_mode_q <= 1'b0;
      raw_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (ctrl_wr_c) begin
        run_q      <= writedata[CTRL_RUN];
        irq_en_q   <= writedata[CTRL_IRQ_EN];
        raw_mode_q <= writedata[CTRL_RAW];
      end
      if (wr_c && address == REG_RAW) raw_q <= writedata[RAW_W-1:0];
      if (push_c && fifo_full && !pop_c && !flush_c) ovf_q <= 1'b1;
      else if (wr_c && address == REG_STATUS && writedata[STAT_OVF]) ovf_q <= 1'b0;
    end
  end

  // Sequencer next state: each phase loads N-1 on entry and leaves at zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (pop_c) begin
        state_d = S_SETUP;
        cnt_d   = SETUP_LD;
      end
      S_SETUP: if (cnt_q == '0) begin
        state_d = S_PULSE;
        cnt_d   = EN_LD;
      end else cnt_d = cnt_q - CNT_W'(1);
      S_PULSE: if (cnt_q == '0) begin
        state_d = S_HOLD;
        cnt_d   = HOLD_LD;
      end else cnt_d = cnt_q - CNT_W'(1);
      S_HOLD: if (cnt_q == '0) begin
        state_d = S_WAIT;
        cnt_d   = is_long_cmd(ent_q) ? LONG_LD : EXEC_LD;
      end else cnt_d = cnt_q - CNT_W'(1);
      S_WAIT: if (cnt_q == '0) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q - CNT_W'(1);
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ent_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop_c) ent_q <= fifo_head;
    end
  end

  // Pin drive: raw register only while the sequencer is idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_data_q <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_rw_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
    end else if (raw_mode_q && state_q == S_IDLE) begin
      {lcd_en_q, lcd_rw_q, lcd_rs_q, lcd_data_q} <= raw_q;
    end else begin
      lcd_en_q   <= (state_d == S_PULSE);
      lcd_rw_q   <= 1'b0;
      lcd_rs_q   <= pop_c ? fifo_head.rs  : ent_q.rs;
      lcd_data_q <= pop_c ? fifo_head.dat : ent_q.dat;
    end
  end

  assign lcd_data = lcd_data_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = lcd_rw_q;
  assign lcd_en   = lcd_en_q;
  assign irq      = irq_en_q & fifo_empty & (state_q == S_IDLE) & ~raw_mode_q;

  always_comb begin
    readdata = '0;
    case (address)
      REG_STATUS: begin
        readdata[STAT_BUSY]           = (state_q != S_IDLE) | ~fifo_empty;
        readdata[STAT_FULL]           = fifo_full;
        readdata[STAT_EMPTY]          = fifo_empty;
        readdata[STAT_OVF]            = ovf_q;
        readdata[STAT_LVL_LSB +: 8]   = 8'(fifo_level);
      end
      REG_CONTROL: begin
        readdata[CTRL_RUN]    = run_q;
        readdata[CTRL_IRQ_EN] = irq_en_q;
        readdata[CTRL_RAW]    = raw_mode_q;
      end
      REG_RAW: readdata[RAW_W-1:0] = raw_q;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_labmininios_lcd_ctrl.sv
// Scoreboard bench: a timeline model predicts register reads and LCD strobes.
module tb_labmininios_lcd_ctrl;

  localparam int D = 16, S = 2, E = 3, H = 1, W = 5, L = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n, read_n;
  logic [31:0] writedata, readdata;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, irq;

  always #5 clk = ~clk;

  labmininios_lcd_ctrl #(
    .FIFO_DEPTH(D), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .EXEC_CYC(W), .LONG_CYC(L)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .irq(irq)
  );

  typedef struct { int edge_no; logic [8:0] ent; } tx_t;
  typedef struct { logic [31:0] rd; logic irq; logic [10:0] pins; } rd_t;

  int n_cmp = 0, n_bad = 0;
  tx_t exp_tx[$];
  rd_t exp_rd[$];

  // Reference model: pending entries, remaining cycles of current transaction
  logic [8:0]  mq[$];
  int          rem, total, edge_n;
  logic [8:0]  cur;
  bit          m_run, m_irqen, m_raw, m_ovf, m_pins_raw;
  logic [10:0] m_rawv, m_pins;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  function automatic bit m_busy();
    return (rem > 0) || (mq.size() > 0);
  endfunction

  function automatic logic m_irq();
    return m_irqen && mq.size() == 0 && rem == 0 && !m_raw;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd1: return {16'd0, 8'(mq.size()), 4'd0, m_ovf, mq.size() == 0, mq.size() == D, m_busy()};
      2'd2: return {28'd0, m_raw, 1'b0, m_irqen, m_run};
      2'd3: return {21'd0, m_rawv};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    rem = 0; total = 0; cur = '0;
    m_run = 0; m_irqen = 0; m_raw = 0; m_ovf = 0; m_pins_raw = 0;
    m_rawv = '0; m_pins = '0;
  endtask

  task automatic model_edge();
    logic wr_b, push, flush, pop, raw_drv, en_b;
    logic [10:0] rawv_pre;
    int elapsed;
    wr_b     = chipselect && !write_n;
    push     = wr_b && address == 2'd0;
    flush    = wr_b && address == 2'd2 && writedata[2];
    pop      = (rem == 0) && m_run && !m_raw && mq.size() > 0 && !flush;
    raw_drv  = m_raw && (rem == 0);
    rawv_pre = m_rawv;
    edge_n++;
    if (rem > 0) rem--;
    if (pop) begin
      cur   = mq.pop_front();
      total = S + E + H + ((!cur[8] && cur[7:0] >= 8'd1 && cur[7:0] <= 8'd3) ? L : W);
      rem   = total;
      exp_tx.push_back('{edge_n + S, cur});
    end
    if (flush) mq.delete();
    else if (push) begin
      if (mq.size() < D) mq.push_back(writedata[8:0]);
      else m_ovf = 1'b1;
    end
    if (wr_b && address == 2'd1 && writedata[3]) m_ovf = 1'b0;
    if (wr_b && address == 2'd2) begin
      m_run = writedata[0]; m_irqen = writedata[1]; m_raw = writedata[3];
    end
    if (wr_b && address == 2'd3) m_rawv = writedata[10:0];
    if (raw_drv) begin
      m_pins = rawv_pre; m_pins_raw = 1'b1;
    end else begin
      elapsed    = total - rem;
      en_b       = (rem > 0) && elapsed >= S && elapsed < S + E;
      m_pins     = {en_b, 1'b0, cur};
      m_pins_raw = 1'b0;
    end
  endtask

  task automatic bus_idle();
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; address = 2'd0; writedata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    bus_idle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
  endtask

  task automatic rd(input logic [1:0] a);
    rd_t r;
    chipselect = 1'b1; read_n = 1'b0; address = a;
    r.rd = m_read(a); r.irq = m_irq(); r.pins = m_pins;
    exp_rd.push_back(r);
    tick();
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && m_busy(); i++) rd(2'd1);
    rd(2'd1);
  endtask

  // Monitor: compares reads and every sequencer EN strobe against the queues
  logic prev_en = 1'b0;
  int   rise_edge = 0;
  always @(negedge clk) begin
    if (!reset_n) prev_en = 1'b0;
    else begin
      if (chipselect && !read_n) begin
        if (exp_rd.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL read_queue: got read with no expectation at edge %0d", edge_n);
        end else begin
          rd_t r;
          r = exp_rd.pop_front();
          chk($sformatf("readdata[a%0d]", address), readdata, r.rd);
          chk("irq", irq, r.irq);
          chk("pins", {lcd_en, lcd_rw, lcd_rs, lcd_data}, r.pins);
        end
      end
      if (m_pins_raw) prev_en = 1'b0;
      else begin
        if (lcd_en && !prev_en) begin
          rise_edge = edge_n;
          if (exp_tx.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL en_unexpected: got EN rise at edge %0d want none", edge_n);
          end else begin
            tx_t t;
            t = exp_tx.pop_front();
            chk("en_rise_edge", edge_n, t.edge_no);
            chk("en_rs_data", {lcd_rs, lcd_data}, t.ent);
            chk("en_rw", lcd_rw, 1'b0);
          end
        end
        if (!lcd_en && prev_en) chk("en_width", edge_n - rise_edge, E);
        prev_en = lcd_en;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    edge_n  = 0;
    reset_n = 1'b0;
    bus_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset values
    rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);

    // Single data byte '8'
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h138);
    repeat (15) rd(2'd1);

    // Clear command (long wait) then entry mode (normal wait)
    wr(2'd0, 32'h001);
    wr(2'd0, 32'h006);
    drain(100);

    // Overflow with run=0, W1C, then push+pop on a full FIFO
    wr(2'd2, 32'h0);
    for (int i = 0; i < 17; i++) wr(2'd0, 32'($urandom_range(0, 511)));
    rd(2'd1);
    wr(2'd1, 32'h8);
    rd(2'd1);
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h141);
    rd(2'd1);
    drain(1000);

    // irq after last of three entries, cleared by next push
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h148); wr(2'd0, 32'h002); wr(2'd0, 32'h169);
    wr(2'd2, 32'h3);
    drain(200);
    wr(2'd0, 32'h121);
    rd(2'd1);
    drain(100);

    // Flush during the first pulse of four
    wr(2'd2, 32'h2);
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h130 + 32'(i));
    wr(2'd2, 32'h3);
    for (int i = 0; i < 50 && !m_pins[10]; i++) rd(2'd1);
    wr(2'd2, 32'h7);
    drain(100);
    repeat (30) rd(2'd1);

    // Randomized traffic including raw-mode toggles mid-transaction
    for (int i = 0; i < 300; i++) begin
      int unsigned k;
      k = $urandom_range(0, 9);
      d = $urandom;
      if (k <= 2) begin
        if ($urandom_range(0, 3) == 0) d[7:0] = 8'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) d[8] = 1'b0;
        wr(2'd0, d);
      end else if (k == 3) begin
        d = '0;
        d[0] = ($urandom_range(0, 3) != 0);
        d[1] = 1'($urandom);
        d[2] = ($urandom_range(0, 7) == 0);
        d[3] = ($urandom_range(0, 3) == 0);
        wr(2'd2, d);
      end else if (k == 4) wr(2'd3, d);
      else if (k == 5) wr(2'd1, d);
      else rd(2'($urandom_range(0, 3)));
    end
    wr(2'd2, 32'h1);
    drain(3000);

    // Raw pin drive, then asynchronous reset
    wr(2'd2, 32'h8);
    wr(2'd3, 32'h7FF);
    rd(2'd3);
    rd(2'd3);
    chk("en_all_seen", 32'(exp_tx.size()), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("pins_async_reset", {lcd_en, lcd_rw, lcd_rs, lcd_data}, 11'd0);
    chk("irq_async_reset", irq, 1'b0);
    repeat (2) @(posedge clk);
    model_reset();
    exp_tx.delete();
    #1 reset_n = 1'b1;
    rd(2'd1); rd(2'd2); rd(2'd3);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
